// File: rtl/ex2_operand_loader.sv
// Byte-stream front end for the Ex2 stage: assembles a 5-byte command frame,
// publishes operands atomically, then fires the enables one cycle later.
module ex2_operand_loader #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [7:0]  a_o,
    output logic [7:0]  b_o,
    output logic [15:0] c_o,
    output logic        sel_ab_o,
    output logic        sel_c_o,
    output logic        sel_minmax_o,
    output logic        comp_en_o,
    output logic        minmax_en_o,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic [7:0]  frame_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMMIT, S_SETTLE, S_FIRE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      ctrl_q, ctrl_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [3:0][7:0] shadow_q, shadow_d;
    logic [7:0]      idle_timer_q, idle_timer_d;
    logic            in_ready_q, in_ready_d;
    logic [7:0]      a_q, a_d, b_q, b_d;
    logic [15:0]     c_q, c_d;
    logic            sel_ab_q, sel_ab_d, sel_c_q, sel_c_d, sel_mm_q, sel_mm_d;
    logic            comp_en_q, comp_en_d, minmax_en_q, minmax_en_d;
    logic            done_q, done_d, err_q, err_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

    logic accept;
    logic timeout_hit;

    assign accept      = in_valid_i & in_ready_q;
    // Abort on the edge where the idle count would reach TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) &&
                         (({1'b0, idle_timer_q} + 9'd1) == 9'(TIMEOUT));

    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        byte_cnt_d   = byte_cnt_q;
        shadow_d     = shadow_q;
        idle_timer_d = idle_timer_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        sel_ab_d     = sel_ab_q;
        sel_c_d      = sel_c_q;
        sel_mm_d     = sel_mm_q;
        comp_en_d    = 1'b0;
        minmax_en_d  = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                idle_timer_d = '0;
                if (accept) begin
                    if (in_data_i[7]) begin
                        ctrl_d     = in_data_i[4:0];
                        byte_cnt_d = '0;
                        state_d    = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    shadow_d[byte_cnt_q] = in_data_i;
                    byte_cnt_d           = byte_cnt_q + 2'd1;
                    idle_timer_d         = '0;
                    if (byte_cnt_q == 2'd3) state_d = S_COMMIT;
                end else if (timeout_hit) begin
                    state_d      = S_IDLE;
                    err_d        = 1'b1;
                    idle_timer_d = '0;
                    byte_cnt_d   = '0;
                    shadow_d     = '0;
                end else begin
                    idle_timer_d = idle_timer_q + 8'd1;
                end
            end
            S_COMMIT: begin
                a_d      = shadow_q[0];
                b_d      = shadow_q[1];
                c_d      = {shadow_q[3], shadow_q[2]};
                sel_ab_d = ctrl_q[2];
                sel_c_d  = ctrl_q[3];
                sel_mm_d = ctrl_q[4];
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                comp_en_d   = ctrl_q[0];
                minmax_en_d = ctrl_q[1];
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = S_FIRE;
            end
            S_FIRE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ctrl_q       <= '0;
            byte_cnt_q   <= '0;
            shadow_q     <= '0;
            idle_timer_q <= '0;
            in_ready_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            sel_ab_q     <= 1'b0;
            sel_c_q      <= 1'b0;
            sel_mm_q     <= 1'b0;
            comp_en_q    <= 1'b0;
            minmax_en_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            byte_cnt_q   <= byte_cnt_d;
            shadow_q     <= shadow_d;
            idle_timer_q <= idle_timer_d;
            in_ready_q   <= in_ready_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            sel_ab_q     <= sel_ab_d;
            sel_c_q      <= sel_c_d;
            sel_mm_q     <= sel_mm_d;
            comp_en_q    <= comp_en_d;
            minmax_en_q  <= minmax_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign a_o          = a_q;
    assign b_o          = b_q;
    assign c_o          = c_q;
    assign sel_ab_o     = sel_ab_q;
    assign sel_c_o      = sel_c_q;
    assign sel_minmax_o = sel_mm_q;
    assign comp_en_o    = comp_en_q;
    assign minmax_en_o  = minmax_en_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_ex2_operand_loader.sv
// Bench for ex2_operand_loader: byte-stream model with a per-frame timeline,
// directed scenarios followed by a randomized frame mix.
module tb_ex2_operand_loader;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  a_o, b_o, frame_cnt_o;
    logic [15:0] c_o;
    logic        sel_ab_o, sel_c_o, sel_minmax_o;
    logic        comp_en_o, minmax_en_o, frame_done_o, frame_err_o;

    always #5 clk = ~clk;

    ex2_operand_loader #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_o         (a_o),
        .b_o         (b_o),
        .c_o         (c_o),
        .sel_ab_o    (sel_ab_o),
        .sel_c_o     (sel_c_o),
        .sel_minmax_o(sel_minmax_o),
        .comp_en_o   (comp_en_o),
        .minmax_en_o (minmax_en_o),
        .frame_done_o(frame_done_o),
        .frame_err_o (frame_err_o),
        .frame_cnt_o (frame_cnt_o)
    );

    int ncmp = 0;
    int nbad = 0;

    // Stimulus stream: 0..255 is a byte, 256+n is an idle gap of n cycles.
    int stim[$];

    // Reference model: byte position in frame, idle count and the edge on
    // which the last frame completed (operands/enables follow on a timeline).
    int          cyc = 0;
    int          done_edge = -100;
    int          pos = -1;
    int          idle = 0;
    int          n_acc = 0;
    logic [7:0]  frame [5];
    logic [7:0]  m_a = 0, m_b = 0, m_cnt = 0;
    logic [15:0] m_c = 0;
    logic        m_sab = 0, m_sc = 0, m_smm = 0;
    logic        m_comp = 0, m_mm = 0, m_done = 0, m_err = 0, m_rdy = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit acc;
        bit isgap;
        int dd;
        isgap = 0;
        @(negedge clk);
        in_valid_i = 1'b0;
        in_data_i  = 8'h00;
        if (stim.size() != 0) begin
            if (stim[0] >= 256) isgap = 1;
            else begin
                in_valid_i = 1'b1;
                in_data_i  = 8'(stim[0]);
            end
        end
        check("in_ready", {15'd0, in_ready_o}, {15'd0, m_rdy});
        acc = in_valid_i && m_rdy && rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (isgap) begin
            stim[0] = stim[0] - 1;
            if (stim[0] == 256) void'(stim.pop_front());
        end else if (acc) begin
            void'(stim.pop_front());
            n_acc++;
        end

        m_comp = 0; m_mm = 0; m_done = 0; m_err = 0;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_c = 0; m_sab = 0; m_sc = 0; m_smm = 0; m_cnt = 0;
            m_rdy = 0; done_edge = -100; pos = -1; idle = 0;
        end else begin
            dd = cyc - done_edge;
            if (dd == 1) begin
                m_a = frame[1]; m_b = frame[2]; m_c = {frame[4], frame[3]};
                m_sab = frame[0][2]; m_sc = frame[0][3]; m_smm = frame[0][4];
            end
            if (dd == 2) begin
                m_comp = frame[0][0]; m_mm = frame[0][1]; m_done = 1;
                m_cnt = m_cnt + 8'd1;
            end
            if (acc) begin
                idle = 0;
                if (pos < 0) begin
                    if (in_data_i[7]) begin frame[0] = in_data_i; pos = 0; end
                    else m_err = 1;
                end else begin
                    pos++;
                    frame[pos] = in_data_i;
                    if (pos == 4) begin done_edge = cyc; pos = -1; end
                end
            end else if (pos >= 0) begin
                idle++;
                if (TO != 0 && idle == TO) begin m_err = 1; pos = -1; idle = 0; end
            end
            m_rdy = (cyc - done_edge) >= 3;
        end

        check("a", {8'd0, a_o}, {8'd0, m_a});
        check("b", {8'd0, b_o}, {8'd0, m_b});
        check("c", c_o, m_c);
        check("sel", {13'd0, sel_ab_o, sel_c_o, sel_minmax_o}, {13'd0, m_sab, m_sc, m_smm});
        check("en", {14'd0, comp_en_o, minmax_en_o}, {14'd0, m_comp, m_mm});
        check("done", {15'd0, frame_done_o}, {15'd0, m_done});
        check("err", {15'd0, frame_err_o}, {15'd0, m_err});
        check("cnt", {8'd0, frame_cnt_o}, {8'd0, m_cnt});
    endtask

    task automatic push_frame(input int c0, input int b1, input int b2, input int b3, input int b4);
        stim.push_back(c0); stim.push_back(b1); stim.push_back(b2);
        stim.push_back(b3); stim.push_back(b4);
    endtask

    task automatic push_gap(input int n);
        if (n > 0) stim.push_back(256 + n);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (stim.size() != 0 && n < budget) begin
            step();
            n++;
        end
        ncmp++;
        assert (stim.size() == 0) else begin
            nbad++;
            $error("FAIL drain_budget: got %0d items left expected 0", stim.size());
        end
        repeat (4) step();
    endtask

    initial begin
        int base;
        int n;

        // Reset held for three cycles, then one cycle for in_ready to rise.
        repeat (3) step();
        rst_n = 1'b1;
        step();
        step();

        // Back-to-back frame.
        push_frame(8'h9F, 8'h12, 8'h34, 8'hCD, 8'hAB);
        drain(100);
        check("b2b_a", {8'd0, a_o}, 16'h0012);
        check("b2b_c", c_o, 16'hABCD);
        check("b2b_sel", {13'd0, sel_ab_o, sel_c_o, sel_minmax_o}, 16'h0007);
        check("b2b_cnt", {8'd0, frame_cnt_o}, 16'h0001);

        // Bad marker, then a comp-only frame.
        stim.push_back(8'h05);
        push_frame(8'h81, 8'h01, 8'h02, 8'h03, 8'h04);
        drain(100);
        check("bad_a", {8'd0, a_o}, 16'h0001);
        check("bad_c", c_o, 16'h0403);

        // Timeout after two bytes; following 0x10 is not a ctrl byte.
        stim.push_back(8'h82); stim.push_back(8'h11);
        push_gap(TO);
        stim.push_back(8'h10);
        drain(100);
        check("to_a", {8'd0, a_o}, 16'h0001);
        check("to_cnt", {8'd0, frame_cnt_o}, 16'h0002);

        // Byte arriving on the would-be timeout edge keeps the frame alive.
        stim.push_back(8'h82); stim.push_back(8'h11);
        push_gap(TO - 1);
        stim.push_back(8'h22); stim.push_back(8'h33); stim.push_back(8'h44);
        drain(100);
        check("edge_b", {8'd0, b_o}, 16'h0022);
        check("edge_cnt", {8'd0, frame_cnt_o}, 16'h0003);

        // Two frames queued with valid held high throughout.
        push_frame(8'h83, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        push_frame(8'h9C, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
        drain(100);
        check("bp_a", {8'd0, a_o}, 16'h00B0);
        check("bp_cnt", {8'd0, frame_cnt_o}, 16'h0005);

        // Reset after three accepted bytes of a frame.
        base = n_acc;
        push_frame(8'h9F, 8'h55, 8'h66, 8'h77, 8'h88);
        n = 0;
        while (n_acc < base + 3 && n < 50) begin step(); n++; end
        check("mid_accepts", 16'(n_acc - base), 16'd3);
        stim.delete();
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_a", {8'd0, a_o}, 16'h0000);
        check("rst_cnt", {8'd0, frame_cnt_o}, 16'h0000);
        rst_n = 1'b1;
        step();
        push_frame(8'h80, 8'hFF, 8'h00, 8'h00, 8'h00);
        drain(100);
        check("post_rst_a", {8'd0, a_o}, 16'h00FF);
        check("post_rst_cnt", {8'd0, frame_cnt_o}, 16'h0001);

        // Randomized mix: bad markers, short gaps, occasional timeouts;
        // enough commits to wrap frame_cnt.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 8) stim.push_back(int'($urandom_range(0, 127)));
            stim.push_back(int'($urandom_range(128, 255)));
            for (int k = 0; k < 4; k++) begin
                n = int'($urandom_range(0, 99));
                if (n < 3) push_gap(int'($urandom_range(TO - 2, TO + 3)));
                else if (n < 20) push_gap(int'($urandom_range(1, 6)));
                stim.push_back(int'($urandom_range(0, 255)));
            end
        end
        drain(30000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/ex2_operand_loader.md
# ex2_operand_loader

Upstream sequencer for the Ex2 compare/min-max/xor stage. It receives a 5-byte command frame over an 8-bit valid/ready stream and assembles the operands `a`, `b`, `c` and selects `sel_ab`, `sel_c`, `sel_minmax`. It presents them to Ex2 all at once, then issues single-cycle `comp_en`/`minmax_en` pulses one cycle after the operands settle. Ex2 evaluates on enable transitions, so every frame produces at most one rising edge per enable.

## Interface
- `TIMEOUT`, default 16: idle cycles allowed between bytes inside a frame before abort; 0 disables the timeout; legal range 0..255.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte.
- `a`  out  8  operand A to Ex2.
- `b`  out  8  operand B to Ex2.
- `c`  out  16  operand C to Ex2.
- `sel_ab`, `sel_c`, `sel_minmax`  out  1 each  Ex2 select lines.
- `comp_en`, `minmax_en`  out  1 each  Ex2 enable pulses.
- `frame_done`  out  1  one-cycle pulse per committed frame.
- `frame_err`  out  1  one-cycle pulse per rejected or aborted frame.
- `frame_cnt`  out  8  count of committed frames.

## Operation
- **Byte acceptance:** a byte is accepted on a rising edge where `in_valid & in_ready`.
- **Frame layout:** byte0 ctrl, byte1 a, byte2 b, byte3 `c[7:0]`, byte4 `c[15:8]`.
- **Ctrl byte fields:**
  - bit7 is the start marker and must be 1.
  - bit0 `comp_req`, bit1 `minmax_req`.
  - bit2 `sel_ab`, bit3 `sel_c`, bit4 `sel_minmax`.
  - bits6:5 are ignored.
- **FSM states:** IDLE, LOAD, COMMIT, SETTLE, FIRE.
  - IDLE: an accepted byte with bit7=1 is latched as ctrl; `byte_cnt`←0; go to LOAD. An accepted byte with bit7=0 is dropped, `frame_err` pulses, and the FSM stays in IDLE.
  - LOAD: each accepted byte is written to shadow register [`byte_cnt`] and `byte_cnt` increments. The 4th accepted byte moves the FSM to COMMIT.
  - COMMIT → SETTLE unconditionally. On this edge `a`, `b`, `c` and `sel_*` are loaded from the shadows/ctrl together. They are never partially updated.
  - SETTLE → FIRE unconditionally. On this edge `comp_en`←`comp_req`, `minmax_en`←`minmax_req`, `frame_done`←1, and `frame_cnt`←`frame_cnt`+1 (wraps 255→0).
  - FIRE → IDLE unconditionally. On this edge `comp_en`, `minmax_en` and `frame_done` return to 0.
- **No-request frame:** ctrl with both req bits 0 still updates the operands and pulses `frame_done`; no enable toggles.
- **Timeout:** `idle_timer` counts consecutive LOAD cycles with no acceptance and clears on every acceptance.
  - When it reaches `TIMEOUT` (and `TIMEOUT`≠0), the FSM goes to IDLE, `frame_err` pulses, and the shadows are discarded.
  - `a`, `b`, `c`, `sel_*` and `frame_cnt` are unchanged.
  - If a byte is accepted on the same edge as the timeout, the acceptance wins: no error.
- **Operand hold:** operand and select outputs hold their value between commits.
- **Stalled input:** bytes presented while `in_ready`=0 are not consumed. The source holds them and they are accepted after the FSM returns to IDLE.

## Timing
- **Reset values** (rst_n=0 at a rising edge): state IDLE; `in_ready`=0; `a`=0, `b`=0, `c`=0; `sel_*`=0; `comp_en`=0, `minmax_en`=0; `frame_done`=0, `frame_err`=0; `frame_cnt`=0; `byte_cnt`=0; `idle_timer`=0.
- **Reset mid-frame:** the partial frame is lost and all outputs return to their reset values.
- **`in_ready` behaviour:** registered, equal to next-state ∈ {IDLE, LOAD}.
  - It is 1 from the first edge after `rst_n` rises.
  - It is 0 during COMMIT, SETTLE and FIRE.
- **Throughput:** 1 byte per cycle while in IDLE/LOAD. Minimum frame period is 8 cycles (5 accepts + COMMIT + SETTLE + FIRE).
- **Latency** (edge E0 accepts byte4):
  - operands valid after E0+1;
  - enables and `frame_done` high for exactly the cycle after E0+2;
  - low again after E0+3, with `in_ready`=1 after E0+3.
- **Enable/operand ordering:** the enables never rise on the same edge that the operands change.
- **Error pulse:** `frame_err` is high for exactly one cycle after the rejecting/aborting edge.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles mid-stream → all outputs at reset values and `in_ready`=0; `in_ready`=1 one cycle after release.
- **Back-to-back frame:** send 0x9F,0x12,0x34,0xCD,0xAB with no gaps → `a`=0x12, `b`=0x34, `c`=0xABCD, all `sel_*`=1, `comp_en`=`minmax_en`=`frame_done`=1 for exactly one cycle, 2 cycles after the 5th accept, one cycle after the operands change; `frame_cnt`=1.
- **Bad marker:** in IDLE send 0x05 → `frame_err` one-cycle pulse, operands unchanged. Follow with 0x81,0x01,0x02,0x03,0x04 → `a`=1, `b`=2, `c`=0x0403, only `comp_en` pulses.
- **Timeout:** send 0x82,0x11, then `in_valid`=0 for 16 cycles → `frame_err` pulses on the 16th idle cycle; `a` and `frame_cnt` are unchanged; the next byte 0x10 is rejected as ctrl.
- **Backpressure:** keep `in_valid`=1 continuously with two full frames queued → the second ctrl byte is held while `in_ready`=0 and accepted on the first IDLE cycle. No byte is lost or duplicated, and `frame_cnt` goes 0→1→2.
- **Reset mid-frame:** apply reset after 3 accepted bytes → outputs return to 0. A following full frame 0x80,0xFF,0x00,0x00,0x00 commits `a`=0xFF with no enable pulse and `frame_done`=1.
